// File: rtl/deserializer_if.sv
// Purpose : serial-in / parallel-out bundle for the ADC deserializer.
// Latency : n/a (signal bundle only).
// Backpressure: none; the serial stream and the word strobe are free-running.
//
// Signals:
//   D        serial data bit, one per clock
//   bit_slip slip request level; a rising edge moves the word boundary one bit later
//   Q        last completed parallel word
//   valid    one-cycle strobe on the cycle Q updates
// Modports: master drives D/bit_slip (data source); slave produces Q/valid (deserializer).
interface deserializer_if #(
  parameter int WIDTH = 8
);
  logic             D;
  logic             bit_slip;
  logic [WIDTH-1:0] Q;
  logic             valid;

  modport master (
    output D,
    output bit_slip,
    input  Q,
    input  valid
  );

  modport slave (
    input  D,
    input  bit_slip,
    output Q,
    output valid
  );
endinterface

// File: rtl/deserializer.sv
// Purpose : 1:WIDTH serial-to-parallel converter with bit-slip word alignment.
// Latency : Q/valid update on the same edge that samples the last bit of a word.
// Backpressure: none; one bit accepted every clock, words are strobed and held.
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset (clears shift register, counter, slip history, Q, valid)
//   bus  deserializer_if.slave: D, bit_slip in; Q, valid out
//
// Build option: DESERIALIZER_LSB_FIRST_EN -- when defined the first received bit
// lands in Q[0]; otherwise the first received bit lands in Q[WIDTH-1].
module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  deserializer_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             slip_q;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;

  logic [WIDTH-1:0] sr_next;
  logic             slip_ev;
  logic             word_done;

  // The word presented on completion is the shift register after this edge's
  // bit is folded in, so the last bit is visible with no extra cycle.
`ifdef DESERIALIZER_LSB_FIRST_EN
  assign sr_next = {bus.D, sr[WIDTH-1:1]};
`else
  assign sr_next = {sr[WIDTH-2:0], bus.D};
`endif

  // Only the rising edge of the request counts, so a held level is one slip.
  assign slip_ev   = bus.bit_slip & ~slip_q;
  // A slip landing on the final bit position wins: the word is deferred one bit.
  assign word_done = (cnt == LAST) && !slip_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      slip_q  <= 1'b0;
      q_r     <= '0;
      valid_r <= 1'b0;
    end else begin
      sr     <= sr_next;
      slip_q <= bus.bit_slip;
      if (word_done) begin
        q_r     <= sr_next;
        valid_r <= 1'b1;
        cnt     <= '0;
      end else begin
        valid_r <= 1'b0;
        // Holding the count for one edge stretches the current word by one bit,
        // which shifts every later boundary by one bit as well.
        if (!slip_ev) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.Q     = q_r;
  assign bus.valid = valid_r;

endmodule

// File: tb/tb_deserializer.sv
// Purpose : directed self-checking bench for the deserializer.
// Latency : checks Q/valid 1 ns after each rising edge.
// Backpressure: n/a.
module tb_deserializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deserializer_if #(.WIDTH(8)) bus ();

  deserializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DESERIALIZER_LSB_FIRST_EN
  localparam logic [7:0] C_ALIGN = 8'hED;
  localparam logic [7:0] C_SLIP1 = 8'hF6;
  localparam logic [7:0] C_SLIP2 = 8'h7B;
`else
  localparam logic [7:0] C_ALIGN = 8'hB7;
  localparam logic [7:0] C_SLIP1 = 8'h6F;
  localparam logic [7:0] C_SLIP2 = 8'hDE;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_sr;
  logic [7:0] m_q;
  logic       m_vld;
  logic       m_prev;
  int         m_since;
  int         m_need;
  logic [7:0] sb[$];

  // observed-timing bookkeeping
  int cyc_since;
  int n_valid;
  int extra;
  int first_int;

  logic [7:0] pat = 8'b1011_0111;
  int pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid   = 0;
    extra     = 0;
    first_int = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic r, input logic d, input logic s);
    logic       ev;
    logic [7:0] w;
    rst          = r;
    bus.D        = d;
    bus.bit_slip = s;
    @(posedge clk);
    if (r) begin
      m_sr = '0; m_q = '0; m_vld = 1'b0; m_prev = 1'b0;
      m_since = 0; m_need = 8;
    end else begin
`ifdef DESERIALIZER_LSB_FIRST_EN
      m_sr = {d, m_sr[7:1]};
`else
      m_sr = {m_sr[6:0], d};
`endif
      ev = s & ~m_prev;
      m_prev = s;
      m_since++;
      if (ev) m_need++;
      if (m_since == m_need) begin
        m_q = m_sr; m_vld = 1'b1;
        sb.push_back(m_sr);
        m_since = 0; m_need = 8;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
    check("valid", {31'b0, bus.valid}, {31'b0, m_vld});
    check("Q_hold", {24'b0, bus.Q}, {24'b0, m_q});
    if (r) begin
      cyc_since = 0;
    end else begin
      cyc_since++;
      if (bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, bus.valid}, 32'd0);
        end else begin
          w = sb.pop_front();
          check("word", {24'b0, bus.Q}, {24'b0, w});
        end
        if (n_valid == 0) first_int = cyc_since;
        extra += cyc_since - 8;
        n_valid++;
        cyc_since = 0;
      end
    end
    if (r) sb.delete();
  endtask

  task automatic sbit(input logic s);
    step(1'b0, pat[7 - (pos % 8)], s);
    pos++;
  endtask

  initial begin
    rst = 1'b1; bus.D = 1'b0; bus.bit_slip = 1'b0;
    cyc_since = 0;
    clear_stats();

    // Reset with D toggling
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_Q", {24'b0, bus.Q}, 32'h0);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);

    // Basic capture: three aligned words
    pos = 0; clear_stats();
    for (int i = 0; i < 24; i++) sbit(1'b0);
    check("basic_first_int", first_int, 8);
    check("basic_n_valid", n_valid, 3);
    check("basic_extra", extra, 0);
    check("basic_word", {24'b0, bus.Q}, {24'b0, C_ALIGN});

    // Single slip mid-word
    clear_stats();
    for (int i = 0; i < 3; i++) sbit(1'b0);
    sbit(1'b1);
    for (int i = 0; i < 36; i++) sbit(1'b0);
    check("slip1_first_int", first_int, 9);
    check("slip1_n_valid", n_valid, 4);
    check("slip1_extra", extra, 1);
    check("slip1_word", {24'b0, bus.Q}, {24'b0, C_SLIP1});

    // Held slip: five cycles high is one event
    step(1'b1, 1'b0, 1'b0);
    pos = 0; clear_stats();
    for (int i = 0; i < 2; i++) sbit(1'b0);
    for (int i = 0; i < 5; i++) sbit(1'b1);
    for (int i = 0; i < 33; i++) sbit(1'b0);
    check("held_n_valid", n_valid, 4);
    check("held_extra", extra, 1);
    check("held_word", {24'b0, bus.Q}, {24'b0, C_SLIP1});

    // Two slips on alternate cycles
    step(1'b1, 1'b0, 1'b0);
    pos = 0; clear_stats();
    for (int i = 0; i < 2; i++) sbit(1'b0);
    sbit(1'b1); sbit(1'b0); sbit(1'b1);
    for (int i = 0; i < 35; i++) sbit(1'b0);
    check("alt_first_int", first_int, 10);
    check("alt_n_valid", n_valid, 4);
    check("alt_extra", extra, 2);
    check("alt_word", {24'b0, bus.Q}, {24'b0, C_SLIP2});

    // Slip on the final bit of a word
    step(1'b1, 1'b0, 1'b0);
    pos = 0;
    for (int i = 0; i < 8; i++) sbit(1'b0);
    clear_stats();
    for (int i = 0; i < 7; i++) sbit(1'b0);
    sbit(1'b1);
    check("bnd_no_valid", {31'b0, bus.valid}, 32'd0);
    sbit(1'b0);
    check("bnd_valid", {31'b0, bus.valid}, 32'd1);
    check("bnd_word", {24'b0, bus.Q}, {24'b0, C_SLIP1});
    for (int i = 0; i < 16; i++) sbit(1'b0);
    check("bnd_extra", extra, 1);
    check("bnd_word_late", {24'b0, bus.Q}, {24'b0, C_SLIP1});

    // Reset after three bits of a word
    step(1'b1, 1'b0, 1'b0);
    pos = 0;
    for (int i = 0; i < 8; i++) sbit(1'b0);
    for (int i = 0; i < 3; i++) sbit(1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_Q", {24'b0, bus.Q}, 32'h0);
    check("midrst_valid", {31'b0, bus.valid}, 32'd0);
    pos = 0; clear_stats();
    for (int i = 0; i < 7; i++) sbit(1'b0);
    check("midrst_no_early", n_valid, 0);
    sbit(1'b0);
    check("midrst_valid_8th", {31'b0, bus.valid}, 32'd1);
    check("midrst_word", {24'b0, bus.Q}, {24'b0, C_ALIGN});
    check("midrst_first_int", first_int, 8);

    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
